// File: rtl/dso_mux_pkg.sv
// Shared types and reset defaults for the DSO channel selector.
package dso_mux_pkg;

   localparam int unsigned MAX_CH    = 16;
   localparam int unsigned MAX_SEL_W = 4;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BLANK  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Sized for the largest channel count; instances use the low bits only.
   typedef struct packed {
      logic [MAX_SEL_W-1:0] sel;
      logic                 scan;
      logic [MAX_CH-1:0]    mask;
   } cfg_t;

   localparam cfg_t CFG_RST = '{sel: '0, scan: 1'b0, mask: '1};

endpackage

// File: rtl/dso_rr_next.sv
// Round-robin helper: next set mask bit above the pointer (with wrap) and lowest set bit.
module dso_rr_next #(
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [SEL_W-1:0]  i_ptr,
   output logic [SEL_W-1:0]  o_next,
   output logic [SEL_W-1:0]  o_lowest
);

   // Descending scans: the last hit is the smallest qualifying index.
   always_comb begin
      o_lowest = '0;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (i_mask[i-1]) o_lowest = SEL_W'(i - 1);
      end
      o_next = o_lowest;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (((i - 1) > 32'(i_ptr)) && i_mask[i-1]) o_next = SEL_W'(i - 1);
      end
   end

endmodule

// File: rtl/dso_chan_mux.sv
// Registered N-channel sample selector with blanked reconfiguration and round-robin scan.
module dso_chan_mux
   import dso_mux_pkg::*;
#(
   parameter  int unsigned NUM_CH    = 4,
   parameter  int unsigned DATA_W    = 8,
   parameter  int unsigned BLANK_CYC = 4,
   localparam int unsigned SEL_W     = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] din,
   input  logic                     din_valid,
   input  logic [SEL_W-1:0]         cfg_sel,
   input  logic                     cfg_scan,
   input  logic [NUM_CH-1:0]        cfg_mask,
   input  logic                     cfg_load,
   output logic                     cfg_busy,
   output logic                     cfg_ack,
   output logic                     cfg_err,
   output logic [DATA_W-1:0]        dout,
   output logic                     dout_valid,
   output logic [SEL_W-1:0]         dout_chan
);

   localparam int unsigned         SEL_SPAN = 1 << SEL_W;
   localparam logic [SEL_SPAN-1:0] CH_EXIST = SEL_SPAN'({NUM_CH{1'b1}});

   state_t            r_state;
   cfg_t              r_cfg;
   cfg_t              r_shadow;
   logic [7:0]        r_blank;
   logic [SEL_W-1:0]  r_ptr;
   logic [DATA_W-1:0] r_din [NUM_CH];
   logic              r_vld;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_vld;
   logic [SEL_W-1:0]  r_dout_chan;
   logic              r_err;

   logic              w_run;
   logic              w_load_ok;
   logic              w_accept;
   logic              w_reject;
   logic              w_fwd;
   logic [SEL_W-1:0]  w_src;
   logic [NUM_CH-1:0] w_rr_mask;
   logic [SEL_W-1:0]  w_rr_next;
   logic [SEL_W-1:0]  w_rr_low;
   logic              w_unused_cfg;

   assign w_run     = (r_state == ST_RUN);
   assign w_load_ok = cfg_scan ? (|cfg_mask) : CH_EXIST[cfg_sel];
   assign w_accept  = w_run & cfg_load & w_load_ok;
   assign w_reject  = w_run & cfg_load & ~w_load_ok;
   // A beat leaves the capture stage only in RUN and not on the cycle a load is accepted.
   assign w_fwd     = r_vld & w_run & ~w_accept;
   assign w_src     = r_cfg.scan ? r_ptr : r_cfg.sel[SEL_W-1:0];
   assign w_rr_mask = (r_state == ST_COMMIT) ? r_shadow.mask[NUM_CH-1:0]
                                             : r_cfg.mask[NUM_CH-1:0];
   assign w_unused_cfg = ^{r_cfg, r_shadow};

   dso_rr_next #(.NUM_CH(NUM_CH)) u_rr_next (
      .i_mask   (w_rr_mask),
      .i_ptr    (r_ptr),
      .o_next   (w_rr_next),
      .o_lowest (w_rr_low)
   );

   always_ff @(posedge clk) begin
      if (din_valid) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            r_din[k] <= din[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_cfg       <= CFG_RST;
         r_shadow    <= CFG_RST;
         r_blank     <= '0;
         r_ptr       <= '0;
         r_vld       <= 1'b0;
         r_dout      <= '0;
         r_dout_vld  <= 1'b0;
         r_dout_chan <= '0;
         r_err       <= 1'b0;
      end else begin
         r_vld      <= din_valid & w_run & ~w_accept;
         r_dout_vld <= w_fwd;
         r_err      <= w_reject;
         if (w_fwd) begin
            r_dout      <= r_din[w_src];
            r_dout_chan <= w_src;
            if (r_cfg.scan) r_ptr <= w_rr_next;
         end
         case (r_state)
            ST_RUN: begin
               if (w_accept) begin
                  r_shadow <= '{sel: MAX_SEL_W'(cfg_sel), scan: cfg_scan, mask: MAX_CH'(cfg_mask)};
                  r_blank  <= 8'(BLANK_CYC);
                  r_state  <= ST_BLANK;
               end
            end
            ST_BLANK: begin
               r_blank <= r_blank - 8'd1;
               if (r_blank == 8'd1) r_state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               r_cfg   <= r_shadow;
               r_ptr   <= w_rr_low;
               r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign cfg_busy   = (r_state == ST_BLANK);
   assign cfg_ack    = (r_state == ST_COMMIT);
   assign cfg_err    = r_err;
   assign dout       = r_dout;
   assign dout_valid = r_dout_vld;
   assign dout_chan  = r_dout_chan;

endmodule

// File: tb/tb_dso_chan_mux.sv
// Directed bench for dso_chan_mux: a 4-channel instance plus a 5-channel one for illegal selects.
module tb_dso_chan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] din;
   logic        din_valid;
   logic [1:0]  cfg_sel;
   logic        cfg_scan;
   logic [3:0]  cfg_mask;
   logic        cfg_load;
   logic        cfg_busy, cfg_ack, cfg_err;
   logic [7:0]  dout;
   logic        dout_valid;
   logic [1:0]  dout_chan;

   logic [39:0] d5_din;
   logic        d5_valid;
   logic [2:0]  d5_sel;
   logic        d5_scan;
   logic [4:0]  d5_mask;
   logic        d5_load;
   logic        d5_busy, d5_ack, d5_err;
   logic [7:0]  d5_dout;
   logic        d5_dout_valid;
   logic [2:0]  d5_chan;

   int checks = 0;
   int errors = 0;
   int seq [3] = '{0, 1, 3};

   always #5 clk = ~clk;

   dso_chan_mux #(.NUM_CH(4), .DATA_W(8), .BLANK_CYC(4)) u_dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .cfg_sel(cfg_sel), .cfg_scan(cfg_scan), .cfg_mask(cfg_mask), .cfg_load(cfg_load),
      .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
      .dout(dout), .dout_valid(dout_valid), .dout_chan(dout_chan)
   );

   dso_chan_mux #(.NUM_CH(5), .DATA_W(8), .BLANK_CYC(2)) u_dut5 (
      .clk(clk), .rst(rst), .din(d5_din), .din_valid(d5_valid),
      .cfg_sel(d5_sel), .cfg_scan(d5_scan), .cfg_mask(d5_mask), .cfg_load(d5_load),
      .cfg_busy(d5_busy), .cfg_ack(d5_ack), .cfg_err(d5_err),
      .dout(d5_dout), .dout_valid(d5_dout_valid), .dout_chan(d5_chan)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({dout, dout_valid, dout_chan, cfg_busy, cfg_ack, cfg_err} !== 14'd0) begin
         errors++;
         $display("FAIL reset_main: got %h want 0", {dout, dout_valid, dout_chan, cfg_busy, cfg_ack, cfg_err});
      end
      checks++;
      if ({d5_dout, d5_dout_valid, d5_chan, d5_busy, d5_ack, d5_err} !== 15'd0) begin
         errors++;
         $display("FAIL reset_ch5: got %h want 0", {d5_dout, d5_dout_valid, d5_chan, d5_busy, d5_ack, d5_err});
      end
      rst = 1'b0;
      step();
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_latency: dout_valid=%b want 0 one cycle after first beat", dout_valid);
      end
      step();
   endtask

   task automatic test_fixed();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({dout_valid, dout_chan, dout} !== {1'b1, 2'd0, 8'h10}) begin
            errors++;
            $display("FAIL fixed_sel0 i=%0d: got v=%b ch=%0d d=%h want v=1 ch=0 d=10", i, dout_valid, dout_chan, dout);
         end
         checks++;
         if ({d5_dout_valid, d5_chan, d5_dout} !== {1'b1, 3'd0, 8'h11}) begin
            errors++;
            $display("FAIL fixed_ch5 i=%0d: got v=%b ch=%0d d=%h want v=1 ch=0 d=11", i, d5_dout_valid, d5_chan, d5_dout);
         end
         step();
      end
   endtask

   task automatic test_load_sel();
      logic eb, ea;
      cfg_sel = 2'd2; cfg_scan = 1'b0; cfg_mask = 4'hF; cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         eb = (k <= 4);
         ea = (k == 5);
         checks++;
         if ({cfg_busy, cfg_ack, dout_valid, cfg_err} !== {eb, ea, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_sel_gap k=%0d: busy/ack/valid/err=%b%b%b%b want %b%b00", k, cfg_busy, cfg_ack, dout_valid, cfg_err, eb, ea);
         end
         step();
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({dout_valid, dout_chan, dout} !== {1'b1, 2'd2, 8'h30}) begin
            errors++;
            $display("FAIL load_sel_data i=%0d: got v=%b ch=%0d d=%h want v=1 ch=2 d=30", i, dout_valid, dout_chan, dout);
         end
         step();
      end
   endtask

   task automatic test_scan();
      int nb;
      logic [1:0] ec;
      logic [7:0] ed;
      logic ev;
      cfg_sel = 2'd0; cfg_scan = 1'b1; cfg_mask = 4'b1011; cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_gap k=%0d: dout_valid=%b want 0", k, dout_valid);
         end
         step();
      end
      nb = 0;
      for (int i = 0; i < 6; i++) begin
         ec = 2'(seq[nb % 3]);
         ed = 8'((seq[nb % 3] + 1) * 16);
         nb++;
         checks++;
         if ({dout_valid, dout_chan, dout} !== {1'b1, ec, ed}) begin
            errors++;
            $display("FAIL scan_const i=%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, dout_valid, dout_chan, dout, ec, ed);
         end
         din_valid = (i < 4);
         step();
      end
      nb = 0;
      for (int t = 0; t < 14; t++) begin
         ev = (t >= 2) && (t % 2 == 0);
         checks++;
         if (dout_valid !== ev) begin
            errors++;
            $display("FAIL scan_sparse_valid t=%0d: dout_valid=%b want %b", t, dout_valid, ev);
         end
         if (ev) begin
            ec = 2'(seq[nb % 3]);
            ed = 8'((seq[nb % 3] + 1) * 16);
            nb++;
            checks++;
            if ({dout_chan, dout} !== {ec, ed}) begin
               errors++;
               $display("FAIL scan_sparse_data t=%0d: got ch=%0d d=%h want ch=%0d d=%h", t, dout_chan, dout, ec, ed);
            end
         end
         din_valid = (t < 12) && (t % 2 == 0);
         step();
      end
   endtask

   task automatic test_reject();
      int nb;
      logic [1:0] ec;
      logic [7:0] ed;
      logic ee;
      din_valid = 1'b1;
      step();
      step();
      nb = 0;
      for (int p = 0; p < 6; p++) begin
         ec = 2'(seq[nb % 3]);
         ed = 8'((seq[nb % 3] + 1) * 16);
         nb++;
         ee = (p == 1);
         checks++;
         if ({dout_valid, cfg_busy, cfg_err, dout_chan, dout} !== {1'b1, 1'b0, ee, ec, ed}) begin
            errors++;
            $display("FAIL reject_mask0 p=%0d: got v=%b busy=%b err=%b ch=%0d d=%h want v=1 busy=0 err=%b ch=%0d d=%h",
                     p, dout_valid, cfg_busy, cfg_err, dout_chan, dout, ee, ec, ed);
         end
         cfg_scan = 1'b1;
         cfg_mask = 4'b0000;
         cfg_load = (p == 0);
         step();
      end
      cfg_mask = 4'hF;
      for (int p = 0; p < 6; p++) begin
         ee = (p == 1) || (p == 3);
         checks++;
         if ({d5_dout_valid, d5_busy, d5_err, d5_chan, d5_dout} !== {1'b1, 1'b0, ee, 3'd0, 8'h11}) begin
            errors++;
            $display("FAIL reject_sel p=%0d: got v=%b busy=%b err=%b ch=%0d d=%h want v=1 busy=0 err=%b ch=0 d=11",
                     p, d5_dout_valid, d5_busy, d5_err, d5_chan, d5_dout, ee);
         end
         d5_scan = 1'b0;
         d5_sel  = (p == 0) ? 3'd5 : 3'd7;
         d5_load = (p == 0) || (p == 2);
         step();
      end
      d5_load = 1'b0;
   endtask

   task automatic test_blank_repeat();
      logic eb, ea;
      cfg_sel = 2'd1; cfg_scan = 1'b0; cfg_mask = 4'hF; cfg_load = 1'b1;
      step();
      for (int k = 1; k <= 7; k++) begin
         eb = (k <= 4);
         ea = (k == 5);
         checks++;
         if ({cfg_busy, cfg_ack, cfg_err, dout_valid} !== {eb, ea, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL blank_repeat k=%0d: busy/ack/err/valid=%b%b%b%b want %b%b00", k, cfg_busy, cfg_ack, cfg_err, dout_valid, eb, ea);
         end
         cfg_load = (k <= 4);
         cfg_sel  = 2'd3;
         cfg_scan = (k == 4);
         cfg_mask = (k == 4) ? 4'b0000 : 4'hF;
         step();
      end
      cfg_load = 1'b0; cfg_scan = 1'b0; cfg_mask = 4'hF;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({dout_valid, dout_chan, dout, cfg_ack} !== {1'b1, 2'd1, 8'h20, 1'b0}) begin
            errors++;
            $display("FAIL blank_repeat_data i=%0d: got v=%b ch=%0d d=%h ack=%b want v=1 ch=1 d=20 ack=0", i, dout_valid, dout_chan, dout, cfg_ack);
         end
         step();
      end
   endtask

   task automatic test_rst_blank();
      cfg_sel = 2'd2; cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      checks++;
      if (cfg_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_blank_busy1: cfg_busy=%b want 1", cfg_busy);
      end
      step();
      checks++;
      if (cfg_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_blank_busy2: cfg_busy=%b want 1", cfg_busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({dout, dout_valid, dout_chan, cfg_busy, cfg_ack, cfg_err} !== 14'd0) begin
         errors++;
         $display("FAIL rst_blank_zero: got %h want 0", {dout, dout_valid, dout_chan, cfg_busy, cfg_ack, cfg_err});
      end
      step();
      checks++;
      if ({dout_valid, cfg_busy, cfg_ack} !== 3'b000) begin
         errors++;
         $display("FAIL rst_blank_refill: v/busy/ack=%b want 000", {dout_valid, cfg_busy, cfg_ack});
      end
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({dout_valid, dout_chan, dout, cfg_busy, cfg_ack} !== {1'b1, 2'd0, 8'h10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_blank_resume i=%0d: got v=%b ch=%0d d=%h busy=%b ack=%b want v=1 ch=0 d=10 busy=0 ack=0",
                     i, dout_valid, dout_chan, dout, cfg_busy, cfg_ack);
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      din = {8'h40, 8'h30, 8'h20, 8'h10};
      din_valid = 1'b1;
      cfg_sel = 2'd0; cfg_scan = 1'b0; cfg_mask = 4'hF; cfg_load = 1'b0;
      d5_din = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      d5_valid = 1'b1;
      d5_sel = 3'd0; d5_scan = 1'b0; d5_mask = 5'h1F; d5_load = 1'b0;
      test_reset();
      test_fixed();
      test_load_sel();
      test_scan();
      test_reject();
      test_blank_repeat();
      test_rst_blank();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
